// File: rtl/csi2_pkt_hdr_tx.sv
// CSI-2 transmit packet framer.
// Accepts a packet request (VC, DT, WC), builds the 32-bit header word with its
// 6-bit ECC, then streams ceil(WC/4) payload words for long packets. The last
// word carries tx_last_o and the byte enables implied by WC[1:0]. A single
// output register stage gives full throughput.
module csi2_pkt_hdr_tx (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_vc_i,
  input  logic [5:0]  req_dt_i,
  input  logic [15:0] req_wc_i,
  input  logic        pld_valid_i,
  output logic        pld_ready_o,
  input  logic [31:0] pld_data_i,
  input  logic        pld_last_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_keep_o,
  output logic        tx_last_o,
  output logic        tx_hdr_o,
  output logic        len_err_o
);

  typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] hdr_q;       // header waiting for the output register
  logic        hdr_last_q;  // header is the whole packet
  logic [1:0]  wc_lo_q;     // WC[1:0], selects keep on the final word
  logic [14:0] cnt_q;       // payload words still to load

  logic [23:0] req_d;
  logic [31:0] req_hdr;
  logic        req_last;
  logic [16:0] wc_sum;
  logic [14:0] req_cnt;
  logic        load_ok;
  logic        last_word;
  logic [3:0]  keep_last;
  logic        ld_req, ld_pend, ld_pld;

  // Header ECC: each parity bit covers the D bits whose receiver syndrome
  // column has that bit set.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  assign req_d     = {req_wc_i, req_vc_i, req_dt_i};
  assign req_hdr   = {2'b00, ecc6(req_d), req_wc_i, req_vc_i, req_dt_i};
  assign req_last  = (req_dt_i < 6'h10) || (req_wc_i == 16'd0);
  assign wc_sum    = {1'b0, req_wc_i} + 17'd3;
  assign req_cnt   = wc_sum[16:2];
  assign load_ok   = !tx_valid_o || tx_ready_i;
  assign last_word = (cnt_q == 15'd1);

  // Byte enables for the final payload word.
  always_comb begin
    keep_last = 4'hF;
    case (wc_lo_q)
      2'd1:    keep_last = 4'h1;
      2'd2:    keep_last = 4'h3;
      2'd3:    keep_last = 4'h7;
      default: keep_last = 4'hF;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshakes. The header goes straight to the output on
  // accept when the register is free so it appears the following cycle;
  // otherwise it parks in HDR until the register drains.
  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    pld_ready_o = 1'b0;
    ld_req      = 1'b0;
    ld_pend     = 1'b0;
    ld_pld      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (load_ok) begin
            ld_req    = 1'b1;
            state_nxt = req_last ? IDLE : PLD;
          end else begin
            state_nxt = HDR;
          end
        end
      end
      HDR: begin
        if (load_ok) begin
          ld_pend   = 1'b1;
          state_nxt = hdr_last_q ? IDLE : PLD;
        end
      end
      PLD: begin
        pld_ready_o = load_ok;
        if (pld_valid_i && load_ok) begin
          ld_pld = 1'b1;
          if (last_word) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and remaining payload word count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hdr_q      <= 32'd0;
      hdr_last_q <= 1'b0;
      wc_lo_q    <= 2'd0;
      cnt_q      <= 15'd0;
    end else if (req_valid_i && req_ready_o) begin
      hdr_q      <= req_hdr;
      hdr_last_q <= req_last;
      wc_lo_q    <= req_wc_i[1:0];
      cnt_q      <= req_cnt;
    end else if (ld_pld) begin
      cnt_q      <= cnt_q - 15'd1;
    end
  end

  // Output register; framing follows WC, pld_last_i only flags a mismatch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_valid_o <= 1'b0;
      tx_data_o  <= 32'd0;
      tx_keep_o  <= 4'h0;
      tx_last_o  <= 1'b0;
      tx_hdr_o   <= 1'b0;
      len_err_o  <= 1'b0;
    end else begin
      len_err_o <= ld_pld && (pld_last_i != last_word);
      if (ld_req || ld_pend) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= ld_req ? req_hdr : hdr_q;
        tx_keep_o  <= 4'hF;
        tx_last_o  <= ld_req ? req_last : hdr_last_q;
        tx_hdr_o   <= 1'b1;
      end else if (ld_pld) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= pld_data_i;
        tx_keep_o  <= last_word ? keep_last : 4'hF;
        tx_last_o  <= last_word;
        tx_hdr_o   <= 1'b0;
      end else if (tx_ready_i) begin
        tx_valid_o <= 1'b0;
      end
    end
  end

endmodule
